// File: rtl/bounce_gen_pkg.sv
// Shared types and constants for the contact-bounce generator.
// No logic and no latency; the package only holds declarations.
// No flow control; constants are consumed by the generator and its LFSR.
package bounce_gen_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        BOUNCE = 1'b1
    } state_t;

    localparam logic [15:0] LFSR_POLY    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // One right-shift step of the Galois LFSR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return (q >> 1) ^ (q[0] ? LFSR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/bounce_generator_lfsr16.sv
// Free-running 16-bit Galois LFSR (poly 0xB400) used as the bounce noise source.
// Latency: new value every clock; q is registered and loads the seed in reset.
// No backpressure: it advances every cycle outside reset.
// Ports: clk, rst (sync, active-high), seed (reset value), q (current state).
module lfsr16
    import bounce_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            // The all-zero state is a lock-up point, so it is never loaded.
            q <= (seed == 16'h0000) ? 16'h0001 : seed;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/bounce_generator.sv
// Contact-bounce model: turns a clean level into a bounded burst of pseudo-random toggles.
// Latency: noisy_out follows a clean_in edge one cycle later; the burst ends BOUNCE_CYCLES later.
// No backpressure: edges are taken every cycle; a new edge mid-burst restarts the burst.
// Ports: clk, rst (sync, active-high), enable (0 = registered pass-through), clean_in,
//        noisy_out (bouncing level), busy (burst active), bounce_done (1-cycle end pulse),
//        glitch_cnt (toggles in current/last burst, saturating at 255).
module bounce_generator
    import bounce_gen_pkg::*;
#(
    parameter int          BOUNCE_CYCLES = 40,
    parameter int          TOGGLE_THRESH = 64,
    parameter logic [15:0] LFSR_SEED     = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       clean_in,
    output logic       noisy_out,
    output logic       busy,
    output logic       bounce_done,
    output logic [7:0] glitch_cnt
);

    localparam int             CNT_W    = $clog2(BOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
    // Nine bits so that a threshold of 256 means "always toggle".
    localparam logic [8:0]     THRESH   = 9'(TOGGLE_THRESH);

    state_t           state;
    logic             target;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      lfsr_q;
    logic             toggle_hit;
    logic             unused_lfsr_hi;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .q    (lfsr_q)
    );

    assign toggle_hit     = ({1'b0, lfsr_q[7:0]} < THRESH);
    assign unused_lfsr_hi = ^lfsr_q[15:8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            noisy_out   <= 1'b0;
            target      <= 1'b0;
            busy        <= 1'b0;
            bounce_done <= 1'b0;
            glitch_cnt  <= 8'd0;
            cnt         <= '0;
        end else begin
            bounce_done <= 1'b0;
            if (!enable) begin
                // Abort any burst silently; glitch_cnt keeps the last figure.
                state     <= IDLE;
                noisy_out <= clean_in;
                target    <= clean_in;
                busy      <= 1'b0;
                cnt       <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        noisy_out <= target;
                        if (clean_in != target) begin
                            target     <= clean_in;
                            noisy_out  <= clean_in;
                            cnt        <= CNT_LOAD;
                            glitch_cnt <= 8'd0;
                            busy       <= 1'b1;
                            state      <= BOUNCE;
                        end
                    end
                    BOUNCE: begin
                        if (clean_in != target) begin
                            // Re-edge restarts the burst toward the new level.
                            target     <= clean_in;
                            noisy_out  <= clean_in;
                            cnt        <= CNT_LOAD;
                            glitch_cnt <= 8'd0;
                        end else if (cnt == '0) begin
                            // Always land on the target, whatever the last toggle left.
                            noisy_out   <= target;
                            busy        <= 1'b0;
                            bounce_done <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            cnt <= cnt - 1'b1;
                            if (toggle_hit) begin
                                noisy_out <= ~noisy_out;
                                if (glitch_cnt != 8'hFF) begin
                                    glitch_cnt <= glitch_cnt + 8'd1;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
